// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int grant_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer wins.
// The pointer moves to (owner + 1) mod N whenever a grant is released.
module rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic [N-1:0] owner,
  input  logic         advance,
  output logic [N-1:0] pick
);

  localparam int IW = grant_idx_width(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] owner_idx;
  logic [IW-1:0] next_ptr;
  logic [IW:0]   cand;
  logic          found;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!found && req[cand[IW-1:0]]) begin
        pick[cand[IW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (owner[i]) owner_idx = IW'(i);
    end
  end

  assign next_ptr = (owner_idx == IW'(N-1)) ? '0 : owner_idx + IW'(1);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        ptr_q <= '0;
    else if (advance) ptr_q <= next_ptr;
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-to-1 Wishbone B4 arbiter with round-robin grant held for the whole cycle
// and a watchdog that aborts a stalled slave access with an error.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT     = 256
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [NUM_MASTERS-1:0]              m_wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_wb_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_wb_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wb_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wb_sel_i,
  input  logic [NUM_MASTERS*3-1:0]            m_wb_cti_i,
  input  logic [NUM_MASTERS*2-1:0]            m_wb_bte_i,
  output logic [NUM_MASTERS-1:0]              m_wb_ack_o,
  output logic [NUM_MASTERS-1:0]              m_wb_err_o,
  output logic [NUM_MASTERS-1:0]              m_wb_rty_o,
  output logic [DATA_WIDTH-1:0]               m_wb_dat_o,
  output logic                                s_wb_cyc_o,
  output logic                                s_wb_stb_o,
  output logic                                s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]               s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]               s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0]             s_wb_sel_o,
  output logic [2:0]                          s_wb_cti_o,
  output logic [1:0]                          s_wb_bte_o,
  input  logic                                s_wb_ack_i,
  input  logic                                s_wb_err_i,
  input  logic                                s_wb_rty_i,
  input  logic [DATA_WIDTH-1:0]               s_wb_dat_i,
  output logic [NUM_MASTERS-1:0]              grant_o,
  output logic                                timeout_o
);

  localparam int SW = DATA_WIDTH / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, pick;
  logic                   advance, busy, abort;
  logic                   granted_cyc, granted_stb, stall, wd_fire;

  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .clk     (clk),
    .rstn    (rstn),
    .req     (m_wb_cyc_i),
    .owner   (grant_q),
    .advance (advance),
    .pick    (pick)
  );

  // Grant is one-hot and zero when idle, so an idle bus muxes to all zeros.
  always_comb begin
    granted_cyc = 1'b0;
    granted_stb = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    s_wb_cti_o  = '0;
    s_wb_bte_o  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        granted_cyc = m_wb_cyc_i[k];
        granted_stb = m_wb_stb_i[k];
        s_wb_we_o   = m_wb_we_i[k];
        s_wb_adr_o  = m_wb_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_wb_dat_o  = m_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        s_wb_sel_o  = m_wb_sel_i[k*SW +: SW];
        s_wb_cti_o  = m_wb_cti_i[k*3 +: 3];
        s_wb_bte_o  = m_wb_bte_i[k*2 +: 2];
      end
    end
  end

  assign busy       = (state_q == BUSY);
  assign abort      = (state_q == ABORT);
  assign s_wb_cyc_o = busy & granted_cyc;
  assign s_wb_stb_o = busy & granted_cyc & granted_stb;
  assign stall      = s_wb_stb_o & ~(s_wb_ack_i | s_wb_err_i | s_wb_rty_i);

  assign m_wb_ack_o = (busy & s_wb_ack_i) ? grant_q : '0;
  assign m_wb_rty_o = (busy & s_wb_rty_i) ? grant_q : '0;
  assign m_wb_err_o = ((busy & s_wb_err_i) | abort) ? grant_q : '0;
  assign m_wb_dat_o = s_wb_dat_i;
  assign grant_o    = grant_q;
  assign timeout_o  = abort;

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q;

    assign wd_fire = stall && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                 cnt_q <= '0;
      else if (stall && !wd_fire) cnt_q <= cnt_q + CW'(1);
      else                       cnt_q <= '0;
    end
  end else begin : g_no_wd
    assign wd_fire = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_wb_cyc_i) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!granted_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          advance = 1'b1;
        end else if (wd_fire) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        advance = 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter: two masters, hand-driven slave, TIMEOUT=8.
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
  logic [N*AW-1:0] m_wb_adr_i;
  logic [N*DW-1:0] m_wb_dat_i;
  logic [N*8-1:0]  m_wb_sel_i;
  logic [N*3-1:0]  m_wb_cti_i;
  logic [N*2-1:0]  m_wb_bte_i;
  logic [N-1:0]    m_wb_ack_o, m_wb_err_o, m_wb_rty_o;
  logic [DW-1:0]   m_wb_dat_o;
  logic            s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [AW-1:0]   s_wb_adr_o;
  logic [DW-1:0]   s_wb_dat_o;
  logic [7:0]      s_wb_sel_o;
  logic [2:0]      s_wb_cti_o;
  logic [1:0]      s_wb_bte_o;
  logic            s_wb_ack_i, s_wb_err_i, s_wb_rty_i;
  logic [DW-1:0]   s_wb_dat_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_wb_cyc_i(m_wb_cyc_i), .m_wb_stb_i(m_wb_stb_i), .m_wb_we_i(m_wb_we_i),
    .m_wb_adr_i(m_wb_adr_i), .m_wb_dat_i(m_wb_dat_i), .m_wb_sel_i(m_wb_sel_i),
    .m_wb_cti_i(m_wb_cti_i), .m_wb_bte_i(m_wb_bte_i),
    .m_wb_ack_o(m_wb_ack_o), .m_wb_err_o(m_wb_err_o), .m_wb_rty_o(m_wb_rty_o),
    .m_wb_dat_o(m_wb_dat_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_cti_o(s_wb_cti_o), .s_wb_bte_o(s_wb_bte_o),
    .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i), .s_wb_rty_i(s_wb_rty_i),
    .s_wb_dat_i(s_wb_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [2:0] cti);
    m_wb_cyc_i[k]            = cyc;
    m_wb_stb_i[k]            = stb;
    m_wb_we_i[k]             = we;
    m_wb_adr_i[k*AW +: AW]   = adr;
    m_wb_dat_i[k*DW +: DW]   = {32'hD0D0_0000, adr};
    m_wb_sel_i[k*8 +: 8]     = 8'hFF;
    m_wb_cti_i[k*3 +: 3]     = cti;
    m_wb_bte_i[k*2 +: 2]     = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rstn = 1'b0;
    m_wb_cyc_i = '0; m_wb_stb_i = '0; m_wb_we_i = '0;
    m_wb_adr_i = '0; m_wb_dat_i = '0; m_wb_sel_i = '0;
    m_wb_cti_i = '0; m_wb_bte_i = '0;
    s_wb_ack_i = 1'b0; s_wb_err_i = 1'b0; s_wb_rty_i = 1'b0; s_wb_dat_i = '0;

    // Reset state
    step();
    check("rst_grant", 64'(grant_o), 64'h0);
    check("rst_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    check("rst_s_stb", 64'(s_wb_stb_o), 64'h0);
    check("rst_ack", 64'(m_wb_ack_o), 64'h0);
    check("rst_err", 64'(m_wb_err_o), 64'h0);
    check("rst_timeout", 64'(timeout_o), 64'h0);
    rstn = 1'b1;
    step();

    // Single master 0 classic read
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, CTI_CLASSIC);
    settle();
    check("t1_idle_grant", 64'(grant_o), 64'h0);
    check("t1_idle_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    step();
    check("t1_grant", 64'(grant_o), 64'h1);
    check("t1_s_cyc", 64'(s_wb_cyc_o), 64'h1);
    check("t1_s_adr", 64'(s_wb_adr_o), 64'h1234_5678);
    check("t1_s_sel", 64'(s_wb_sel_o), 64'hFF);
    check("t1_s_bte", 64'(s_wb_bte_o), 64'h0);
    check("t1_no_ack", 64'(m_wb_ack_o), 64'h0);
    step();
    check("t1_wait_ack", 64'(m_wb_ack_o), 64'h0);
    s_wb_ack_i = 1'b1;
    s_wb_dat_i = 64'hCAFE_F00D_1234_5678;
    settle();
    check("t1_ack", 64'(m_wb_ack_o), 64'h1);
    check("t1_rdata", m_wb_dat_o, 64'hCAFE_F00D_1234_5678);
    step();
    s_wb_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    settle();
    check("t1_drop_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    step();
    check("t1_release", 64'(grant_o), 64'h0);

    // Simultaneous requests just after reset
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, CTI_CLASSIC);
    step();
    check("t2_first_m0", 64'(grant_o), 64'h1);
    check("t2_s_adr_m0", 64'(s_wb_adr_o), 64'h100);
    s_wb_ack_i = 1'b1;
    settle();
    check("t2_ack_m0", 64'(m_wb_ack_o), 64'h1);
    step();
    s_wb_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    settle();
    check("t2_hold", 64'(grant_o), 64'h1);
    step();
    check("t2_dead_cycle", 64'(grant_o), 64'h0);
    check("t2_dead_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    step();
    check("t2_second_m1", 64'(grant_o), 64'h2);
    check("t2_s_adr_m1", 64'(s_wb_adr_o), 64'h200);
    s_wb_ack_i = 1'b1;
    settle();
    check("t2_ack_m1", 64'(m_wb_ack_o), 64'h2);
    step();
    s_wb_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    step();

    // Continuous requests alternate
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, CTI_CLASSIC);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, CTI_CLASSIC);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      check($sformatf("t3_grant_%0d", i), 64'(grant_o), 64'(exp_g));
      s_wb_ack_i = 1'b1;
      settle();
      check($sformatf("t3_ack_%0d", i), 64'(m_wb_ack_o), 64'(exp_g));
      step();
      s_wb_ack_i = 1'b0;
      set_m(i % 2, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
      step();
      if (i < 5) set_m(i % 2, 1'b1, 1'b1, 1'b0, 32'h0000_3000 + 32'(i), CTI_CLASSIC);
      else       set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    end

    // Master 1 incrementing burst while master 0 waits
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_4000, CTI_INCR);
    step();
    check("t4_grant_m1", 64'(grant_o), 64'h2);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_5000, CTI_CLASSIC);
    for (int b = 0; b < 4; b++) begin
      logic [2:0] cti;
      cti = (b == 3) ? CTI_EOB : CTI_INCR;
      set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_4000 + 32'(b * 8), cti);
      s_wb_ack_i = 1'b1;
      settle();
      check($sformatf("t4_ack_%0d", b), 64'(m_wb_ack_o), 64'h2);
      check($sformatf("t4_s_cyc_%0d", b), 64'(s_wb_cyc_o), 64'h1);
      check($sformatf("t4_cti_%0d", b), 64'(s_wb_cti_o), 64'(cti));
      check($sformatf("t4_adr_%0d", b), 64'(s_wb_adr_o), 64'h4000 + 64'(b * 8));
      check($sformatf("t4_grant_%0d", b), 64'(grant_o), 64'h2);
      step();
    end
    s_wb_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    settle();
    check("t4_m0_waits", 64'(grant_o), 64'h2);
    step();
    check("t4_dead_cycle", 64'(grant_o), 64'h0);
    step();
    check("t4_grant_m0", 64'(grant_o), 64'h1);
    s_wb_ack_i = 1'b1;
    settle();
    check("t4_ack_m0", 64'(m_wb_ack_o), 64'h1);
    step();
    s_wb_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    step();

    // Watchdog: master 0 write never acknowledged
    set_m(0, 1'b1, 1'b1, 1'b1, 32'h0000_6000, CTI_CLASSIC);
    step();
    check("t5_grant_m0", 64'(grant_o), 64'h1);
    check("t5_s_we", 64'(s_wb_we_o), 64'h1);
    check("t5_s_wdata", s_wb_dat_o, 64'hD0D0_0000_0000_6000);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_7000, CTI_CLASSIC);
    for (int i = 2; i <= 8; i++) begin
      step();
      check($sformatf("t5_stall_err_%0d", i), 64'(m_wb_err_o), 64'h0);
      check($sformatf("t5_stall_to_%0d", i), 64'(timeout_o), 64'h0);
      check($sformatf("t5_stall_cyc_%0d", i), 64'(s_wb_cyc_o), 64'h1);
    end
    step();
    s_wb_ack_i = 1'b1;
    settle();
    check("t5_abort_err", 64'(m_wb_err_o), 64'h1);
    check("t5_abort_timeout", 64'(timeout_o), 64'h1);
    check("t5_abort_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    check("t5_abort_s_stb", 64'(s_wb_stb_o), 64'h0);
    check("t5_abort_ack_dropped", 64'(m_wb_ack_o), 64'h0);
    step();
    s_wb_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    settle();
    check("t5_timeout_pulse", 64'(timeout_o), 64'h0);
    check("t5_err_pulse", 64'(m_wb_err_o), 64'h0);
    check("t5_idle", 64'(grant_o), 64'h0);
    step();
    check("t5_grant_m1", 64'(grant_o), 64'h2);
    s_wb_ack_i = 1'b1;
    settle();
    check("t5_ack_m1", 64'(m_wb_ack_o), 64'h2);
    step();
    s_wb_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    step();

    // Master 0 retried access moves the pointer to master 1
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_8000, CTI_CLASSIC);
    step();
    s_wb_rty_i = 1'b1;
    settle();
    check("t6_rty_m0", 64'(m_wb_rty_o), 64'h1);
    check("t6_rty_no_ack", 64'(m_wb_ack_o), 64'h0);
    step();
    s_wb_rty_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    step();

    // Reset during beat 2 of a master 1 burst
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_9000, CTI_INCR);
    step();
    check("t7_grant_m1", 64'(grant_o), 64'h2);
    s_wb_ack_i = 1'b1;
    step();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_9008, CTI_INCR);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_A000, CTI_CLASSIC);
    settle();
    check("t7_beat2_ack", 64'(m_wb_ack_o), 64'h2);
    rstn = 1'b0;
    settle();
    check("t7_rst_s_cyc", 64'(s_wb_cyc_o), 64'h0);
    check("t7_rst_grant", 64'(grant_o), 64'h0);
    check("t7_rst_ack", 64'(m_wb_ack_o), 64'h0);
    check("t7_rst_err", 64'(m_wb_err_o), 64'h0);
    check("t7_rst_rty", 64'(m_wb_rty_o), 64'h0);
    step();
    rstn = 1'b1;
    s_wb_ack_i = 1'b0;
    step();
    check("t7_post_reset_prio", 64'(grant_o), 64'h1);
    s_wb_ack_i = 1'b1;
    settle();
    check("t7_ack_m0", 64'(m_wb_ack_o), 64'h1);
    step();
    s_wb_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, CTI_CLASSIC);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
